// File: rtl/deal_sequencer.sv
// Deal sequencer: moves cards from the shuffled-deck memory into hole, flop, turn and river registers.
// Optional macro BURN_CARDS_EN inserts one burn card before the flop, turn and river.
module deal_sequencer #(
  parameter int DECK_SIZE  = 52,
  parameter int RD_LATENCY = 1,
  parameter int CARD_W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   deal_start,
  input  logic                   stage_req,
  input  logic [1:0]             stage_sel,
  output logic                   busy,
  output logic                   stage_done,
  output logic                   error,
  output logic                   deck_rd_en,
  output logic [5:0]             deck_rd_addr,
  input  logic [CARD_W-1:0]      deck_rd_data,
  output logic [1:0][CARD_W-1:0] player1_cards,
  output logic [1:0][CARD_W-1:0] player2_cards,
  output logic [2:0][CARD_W-1:0] flop_cards,
  output logic [CARD_W-1:0]      turn_card,
  output logic [CARD_W-1:0]      river_card,
  output logic [5:0]             deck_ptr
);

  typedef enum logic [2:0] {S_IDLE, S_BURN, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic [2:0] {ST_HOLE = 3'd0, ST_FLOP = 3'd1, ST_TURN = 3'd2,
                            ST_RIVER = 3'd3, ST_NONE = 3'd4} stage_e;

`ifdef BURN_CARDS_EN
  localparam logic BURN_EN = 1'b1;
`else
  localparam logic BURN_EN = 1'b0;
`endif

  localparam logic [6:0] BURN_CNT   = {6'd0, BURN_EN};
  localparam logic [6:0] DECK_LIMIT = 7'(DECK_SIZE);
  localparam int         WCNT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LATENCY - 1);

  state_e                   state_q, state_d;
  stage_e                   stage_q, stage_d;
  stage_e                   exp_q, exp_d;
  stage_e                   req_stage;
  logic                     req_ok;
  logic [5:0]               ptr_q, ptr_d;
  logic [1:0]               idx_q, idx_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic                     error_q, error_d;
  logic [1:0][CARD_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [2:0][CARD_W-1:0]   flop_q, flop_d;
  logic [CARD_W-1:0]        turn_q, turn_d, river_q, river_d;

  function automatic logic [6:0] cards_needed(input stage_e s);
    case (s)
      ST_HOLE: cards_needed = 7'd4;
      ST_FLOP: cards_needed = 7'd3 + BURN_CNT;
      default: cards_needed = 7'd1 + BURN_CNT;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input stage_e s);
    case (s)
      ST_HOLE: last_idx = 2'd3;
      ST_FLOP: last_idx = 2'd2;
      default: last_idx = 2'd0;
    endcase
  endfunction

  // NOTE: every variable gets its hold value first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    exp_d   = exp_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    error_d = 1'b0;
    p1_d    = p1_q;
    p2_d    = p2_q;
    flop_d  = flop_q;
    turn_d  = turn_q;
    river_d = river_q;

    // stage_sel is 2 bits, so it never matches ST_NONE after the river.
    req_stage = stage_e'({1'b0, stage_sel});
    req_ok    = (req_stage == exp_q) &&
                (({1'b0, ptr_q} + cards_needed(req_stage)) <= DECK_LIMIT);

    unique case (state_q)
      S_IDLE: begin
        if (stage_req) begin
          if (req_ok) begin
            stage_d = req_stage;
            idx_d   = 2'd0;
            state_d = (req_stage != ST_HOLE && BURN_EN) ? S_BURN : S_ISSUE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_BURN: begin
        ptr_d   = ptr_q + 6'd1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ptr_d   = ptr_q + 6'd1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          unique case (stage_q)
            ST_HOLE: begin
              if (idx_q[0]) p2_d[idx_q[1]] = deck_rd_data;
              else          p1_d[idx_q[1]] = deck_rd_data;
            end
            ST_FLOP: begin
              case (idx_q)
                2'd0:    flop_d[0] = deck_rd_data;
                2'd1:    flop_d[1] = deck_rd_data;
                default: flop_d[2] = deck_rd_data;
              endcase
            end
            ST_TURN:  turn_d  = deck_rd_data;
            ST_RIVER: river_d = deck_rd_data;
            default: ;
          endcase
          if (idx_q == last_idx(stage_q)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        case (stage_q)
          ST_HOLE:  exp_d = ST_FLOP;
          ST_FLOP:  exp_d = ST_TURN;
          ST_TURN:  exp_d = ST_RIVER;
          default:  exp_d = ST_NONE;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (stage_req && state_q != S_IDLE) error_d = 1'b1;

    // A new hand overrides everything, including a simultaneous request.
    if (deal_start) begin
      state_d = S_IDLE;
      exp_d   = ST_HOLE;
      ptr_d   = '0;
      idx_d   = '0;
      wcnt_d  = '0;
      error_d = 1'b0;
      p1_d    = '0;
      p2_d    = '0;
      flop_d  = '0;
      turn_d  = '0;
      river_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the card registers are few
  // enough to reset like any other flop rather than being treated as a memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= ST_HOLE;
      exp_q   <= ST_HOLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      error_q <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      flop_q  <= '0;
      turn_q  <= '0;
      river_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      exp_q   <= exp_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      error_q <= error_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      flop_q  <= flop_d;
      turn_q  <= turn_d;
      river_q <= river_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign stage_done    = (state_q == S_DONE);
  assign deck_rd_en    = (state_q == S_ISSUE);
  assign deck_rd_addr  = (state_q == S_ISSUE) ? ptr_q : 6'd0;
  assign error         = error_q;
  assign deck_ptr      = ptr_q;
  assign player1_cards = p1_q;
  assign player2_cards = p2_q;
  assign flop_cards    = flop_q;
  assign turn_card     = turn_q;
  assign river_card    = river_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: DUT a (52 cards, latency 1) and DUT b (short deck, latency 3).
// Expectations adapt to whether BURN_CARDS_EN is defined.
module tb_deal_sequencer;

`ifdef BURN_CARDS_EN
  localparam int B_DECK   = 10;
  localparam int FLOP_CYC = 8;
  localparam int TURN_CYC = 4;
  localparam int FLOP_B   = 14;
  localparam int TURN_B   = 6;
  localparam logic [17:0] FLOP_EXP  = {6'd8, 6'd7, 6'd6};
  localparam logic [5:0]  TURN_EXP  = 6'd10;
  localparam logic [5:0]  RIVER_EXP = 6'd12;
  localparam logic [5:0]  PTR_END   = 6'd12;
`else
  localparam int B_DECK   = 8;
  localparam int FLOP_CYC = 7;
  localparam int TURN_CYC = 3;
  localparam int FLOP_B   = 13;
  localparam int TURN_B   = 5;
  localparam logic [17:0] FLOP_EXP  = {6'd7, 6'd6, 6'd5};
  localparam logic [5:0]  TURN_EXP  = 6'd8;
  localparam logic [5:0]  RIVER_EXP = 6'd9;
  localparam logic [5:0]  PTR_END   = 6'd9;
`endif
  localparam logic [11:0] P1_EXP = {6'd3, 6'd1};
  localparam logic [11:0] P2_EXP = {6'd4, 6'd2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tb_start = 1'b0, tb_req = 1'b0, use_b = 1'b0;
  logic [1:0] tb_sel = 2'd0;
  int checks = 0, errors = 0;

  logic start_a, req_a, busy_a, done_a, err_a, rd_en_a;
  logic start_b, req_b, busy_b, done_b, err_b, rd_en_b;
  logic [5:0] addr_a, addr_b, ptr_a, ptr_b, data_a, data_b;
  logic [1:0][5:0] p1_a, p2_a, p1_b, p2_b;
  logic [2:0][5:0] flop_a, flop_b;
  logic [5:0] turn_a, river_a, turn_b, river_b;
  logic [5:0] pipe_b [3];

  assign start_a = tb_start & ~use_b;
  assign req_a   = tb_req & ~use_b;
  assign start_b = tb_start & use_b;
  assign req_b   = tb_req & use_b;

  always #5 clk = ~clk;

  // Deck contents are deck[i] = i+1; 63 marks cycles where read data is not valid.
  always @(posedge clk) data_a <= rd_en_a ? 6'(addr_a + 6'd1) : 6'h3F;
  always @(posedge clk) begin
    pipe_b[0] <= rd_en_b ? 6'(addr_b + 6'd1) : 6'h3F;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign data_b = pipe_b[2];

  deal_sequencer #(.DECK_SIZE(52), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .deal_start(start_a), .stage_req(req_a), .stage_sel(tb_sel),
    .busy(busy_a), .stage_done(done_a), .error(err_a), .deck_rd_en(rd_en_a),
    .deck_rd_addr(addr_a), .deck_rd_data(data_a), .player1_cards(p1_a),
    .player2_cards(p2_a), .flop_cards(flop_a), .turn_card(turn_a), .river_card(river_a),
    .deck_ptr(ptr_a));

  deal_sequencer #(.DECK_SIZE(B_DECK), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .deal_start(start_b), .stage_req(req_b), .stage_sel(tb_sel),
    .busy(busy_b), .stage_done(done_b), .error(err_b), .deck_rd_en(rd_en_b),
    .deck_rd_addr(addr_b), .deck_rd_data(data_b), .player1_cards(p1_b),
    .player2_cards(p2_b), .flop_cards(flop_b), .turn_card(turn_b), .river_card(river_b),
    .deck_ptr(ptr_b));

  logic m_busy, m_done, m_err, m_rd_en;
  logic [5:0] m_ptr, m_turn, m_river;
  logic [11:0] m_p1, m_p2;
  logic [17:0] m_flop;
  assign m_busy  = use_b ? busy_b  : busy_a;
  assign m_done  = use_b ? done_b  : done_a;
  assign m_err   = use_b ? err_b   : err_a;
  assign m_rd_en = use_b ? rd_en_b : rd_en_a;
  assign m_ptr   = use_b ? ptr_b   : ptr_a;
  assign m_p1    = use_b ? p1_b    : p1_a;
  assign m_p2    = use_b ? p2_b    : p2_a;
  assign m_flop  = use_b ? flop_b  : flop_a;
  assign m_turn  = use_b ? turn_b  : turn_a;
  assign m_river = use_b ? river_b : river_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Requests a stage and follows it to stage_done, counting cycles and reads.
  task automatic deal(input logic [1:0] sel, input int exp_cyc, input int gap,
                      input int inj_at, input string tag);
    int n, reads, last_rd, gap_bad;
    logic err_seen;
    @(negedge clk); tb_sel = sel; tb_req = 1'b1;
    @(negedge clk); tb_req = 1'b0;
    n = 1; reads = 0; last_rd = -1; gap_bad = 0; err_seen = 1'b0;
    while (n < 60) begin
      if (m_err) err_seen = 1'b1;
      if (m_rd_en) begin
        if (last_rd >= 0 && n - last_rd != gap) gap_bad++;
        last_rd = n;
        reads++;
      end
      if (m_done) break;
      if (n == inj_at) begin tb_req = 1'b1; tb_sel = 2'd1; end
      else tb_req = 1'b0;
      @(negedge clk); n++;
    end
    tb_req = 1'b0;
    check({tag, " done cycle"}, n, exp_cyc);
    check({tag, " reads"}, reads, (sel == 2'd0) ? 4 : (sel == 2'd1) ? 3 : 1);
    check({tag, " read gap"}, gap_bad, 0);
    check({tag, " error seen"}, {31'd0, err_seen}, (inj_at > 0) ? 1 : 0);
  endtask

  task automatic reject(input logic [1:0] sel, input logic [5:0] exp_ptr, input string tag);
    @(negedge clk); tb_sel = sel; tb_req = 1'b1;
    @(negedge clk); tb_req = 1'b0;
    check({tag, " error"}, {31'd0, m_err}, 1);
    check({tag, " rd_en"}, {31'd0, m_rd_en}, 0);
    check({tag, " busy"}, {31'd0, m_busy}, 0);
    @(negedge clk);
    check({tag, " error pulse"}, {31'd0, m_err}, 0);
    check({tag, " ptr"}, {26'd0, m_ptr}, {26'd0, exp_ptr});
  endtask

  task automatic pulse_start();
    @(negedge clk); tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
  endtask

  initial begin
    logic done_seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", {31'd0, m_busy}, 0);
    check("rst done", {31'd0, m_done}, 0);
    check("rst error", {31'd0, m_err}, 0);
    check("rst rd_en", {31'd0, m_rd_en}, 0);
    check("rst addr", {26'd0, addr_a}, 0);
    check("rst ptr", {26'd0, m_ptr}, 0);
    check("rst cards", {m_p1, m_p2}, 0);

    pulse_start();
    reject(2'd2, 6'd0, "turn first");
    deal(2'd0, 9, 2, 3, "hole");
    check("hole p1", m_p1, P1_EXP);
    check("hole p2", m_p2, P2_EXP);
    check("hole ptr", m_ptr, 4);
    deal(2'd1, FLOP_CYC, 2, 0, "flop");
    check("flop cards", m_flop, FLOP_EXP);
    check("flop keeps p1", m_p1, P1_EXP);
    deal(2'd2, TURN_CYC, 2, 0, "turn");
    check("turn card", m_turn, TURN_EXP);
    deal(2'd3, TURN_CYC, 2, 0, "river");
    check("river card", m_river, RIVER_EXP);
    check("river ptr", m_ptr, PTR_END);
    reject(2'd0, PTR_END, "after river");

    // deal_start together with stage_req: request dropped silently.
    @(negedge clk); tb_start = 1'b1; tb_req = 1'b1; tb_sel = 2'd0;
    @(negedge clk); tb_start = 1'b0; tb_req = 1'b0;
    check("start+req error", {31'd0, m_err}, 0);
    check("start+req busy", {31'd0, m_busy}, 0);
    check("start clears cards", {m_p1, m_flop, m_river}, 0);
    check("start clears ptr", m_ptr, 0);
    deal(2'd0, 9, 2, 0, "hole2");

    // Abort the flop in cycle 5.
    @(negedge clk); tb_sel = 2'd1; tb_req = 1'b1;
    @(negedge clk); tb_req = 1'b0;
    repeat (4) @(negedge clk);
    tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    check("abort busy", {31'd0, m_busy}, 0);
    check("abort ptr", m_ptr, 0);
    check("abort cards", {m_p1, m_p2, m_flop}, 0);
    done_seen = m_done;
    repeat (4) begin
      @(negedge clk);
      done_seen |= m_done;
    end
    check("abort no done", {31'd0, done_seen}, 0);
    check("abort late data", m_flop, 0);

    use_b = 1'b1;
    @(negedge clk);
    check("b rst ptr", m_ptr, 0);
    deal(2'd0, 17, 4, 0, "b hole");
    check("b p1", m_p1, P1_EXP);
    check("b p2", m_p2, P2_EXP);
    deal(2'd1, FLOP_B, 4, 0, "b flop");
    check("b flop cards", m_flop, FLOP_EXP);
    deal(2'd2, TURN_B, 4, 0, "b turn");
    check("b turn card", m_turn, TURN_EXP);
    check("b ptr full", m_ptr, B_DECK);
    reject(2'd3, 6'(B_DECK), "b river bound");
    check("b river untouched", m_river, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
- Sequences card dealing from the shuffled-deck memory into the hand's card registers: hole cards, flop, turn and river.
- Driven by the game FSM, one stage request per betting street.
- Owns the deck read port and the deck pointer, inserts burn cards, and enforces stage order and deck bounds.
- Card outputs feed the FSM's player and community card state.

Parameters:
DECK_SIZE, 52, number of valid deck entries (addresses 0..DECK_SIZE-1)
RD_LATENCY, 1, deck memory read latency in cycles (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
deal_start  in  1  pulse: new hand; clears pointer, cards and expected stage
stage_req  in  1  pulse: deal stage selected by stage_sel
stage_sel  in  2  0=hole, 1=flop, 2=turn, 3=river
busy  out  1  high while a stage is in progress (includes stage_done cycle)
stage_done  out  1  one-cycle pulse when the requested stage's cards are all valid
error  out  1  one-cycle pulse: request rejected
deck_rd_en  out  1  deck read strobe
deck_rd_addr  out  6  deck read address
deck_rd_data  in  card_t  deck data, valid RD_LATENCY cycles after deck_rd_en
player1_cards  out  card_t[2]  hole cards, player 1
player2_cards  out  card_t[2]  hole cards, player 2
flop_cards  out  card_t[3]  flop
turn_card  out  card_t  turn
river_card  out  card_t  river
deck_ptr  out  6  next deck address to consume

Behaviour:
- Reset: all card outputs '0, deck_ptr=0, busy=0, stage_done=0, error=0, deck_rd_en=0, deck_rd_addr=0, expected stage=hole, FSM=IDLE.
- FSM states: IDLE, BURN, ISSUE, WAIT, DONE.
- IDLE:
  - stage_req is accepted only if stage_sel == expected stage AND deck_ptr + cards_needed <= DECK_SIZE.
  - cards_needed: hole=4; flop=3+burn; turn=1+burn; river=1+burn (burn = 1).
  - On acceptance: go to BURN for flop/turn/river, or to ISSUE for hole.
  - Otherwise: pulse error in the next cycle and stay in IDLE.
- BURN: one cycle, no read; deck_ptr += 1; go to ISSUE.
- ISSUE:
  - deck_rd_en=1 and deck_rd_addr=deck_ptr for exactly one cycle.
  - deck_ptr += 1.
  - Go to WAIT for RD_LATENCY cycles.
- WAIT: on the clock edge ending the last WAIT cycle, capture deck_rd_data into the destination slot. Then go to ISSUE if cards remain, else DONE.
- Hole deal order: p1[0], p2[0], p1[1], p2[1].
- Flop deal order: flop[0..2].
- DONE: stage_done=1 for one cycle; expected stage advances (river -> none, all further stage_req rejected until deal_start); return to IDLE.
- busy=1 in all states except IDLE.
- Only one read is ever outstanding.
- Timing at RD_LATENCY=1, with the request sampled at edge 0:
  - hole: stage_done in cycle 9.
  - flop: stage_done in cycle 8.
  - turn/river: stage_done in cycle 4.
- stage_req while busy: ignored; error pulses; the in-progress stage is unaffected.
- deal_start in any state:
  - next cycle: IDLE, deck_ptr=0, all cards '0, expected=hole.
  - Any in-progress stage is aborted with no stage_done; a read in flight is discarded.
- deal_start and stage_req in the same cycle: deal_start wins; the request is dropped without error.
- Card registers hold their values between stages; only the slots of the active stage are written.
- deck_ptr never exceeds DECK_SIZE.

Optional Feature:
BURN_CARDS_EN
- Defined: burn cycle before flop, turn and river as above. Default addresses: hole 0-3, flop 5-7, turn 9, river 11.
- Undefined: BURN state is never entered and burn is not counted in cards_needed. Addresses are contiguous: hole 0-3, flop 4-6, turn 7, river 8.
- Undefined timing: flop stage_done in cycle 7; turn/river stage_done in cycle 3.

Test Plan:
- deck[i]=i+1, deal_start, then hole/flop/turn/river in order (BURN_CARDS_EN defined) -> p1={1,3}, p2={2,4}, flop={6,7,8}, turn=10, river=12, deck_ptr=12, stage_done each stage with exact cycle counts 9/8/4/4.
- After deal_start, stage_req with stage_sel=2 (turn) -> error pulse, no deck_rd_en, deck_ptr=0; then a hole request succeeds normally.
- stage_req during the hole deal (cycle 3) -> error pulse; hole completes with the correct cards, stage_done in cycle 9.
- deal_start in cycle 5 of the flop deal -> no stage_done, all cards 0, deck_ptr=0 next cycle; a late deck_rd_data is not captured.
- DECK_SIZE=10: hole, flop, turn succeed (deck_ptr=10); river request -> error, no read, deck_ptr stays 10.
- RD_LATENCY=3, hole deal -> deck_rd_en pulses spaced 4 cycles apart, cards correct, stage_done in cycle 17; with BURN_CARDS_EN undefined, full hand addresses 0..8.
